pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline: IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and serialises the multi-cycle mult/div unit that writes HI/LO.
- Sequences the CP0 exception/eret flush and drives the 2-bit cp0bubble code that the EX/MEM register uses to squash mem_cp0op.
- Sits beside the decode stage; all its outputs are consumed by the pipeline registers and the PC unit.

---
 rtl/pipe_hazard_ctrl_if.sv | 38 +++
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between decode/EX/MEM control and the hazard sequencer.
// master = pipeline side driving hazard inputs, slave = the sequencer itself.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [1:0] id_md_op;
  logic       id_reads_hl;
  logic [4:0] ex_rw;
  logic       ex_regWr;
  logic [1:0] ex_memtoreg;
  logic       mem_exc;
  logic       mem_eret;
  logic       pc_stall;
  logic       ifid_stall;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic [1:0] cp0bubble;
  logic       md_start;
  logic       md_busy;
  logic       pc_redirect;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_op, id_reads_hl,
           ex_rw, ex_regWr, ex_memtoreg, mem_exc, mem_eret,
    input  pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush,
           cp0bubble, md_start, md_busy, pc_redirect
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_op, id_reads_hl,
           ex_rw, ex_regWr, ex_memtoreg, mem_exc, mem_eret,
    output pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush,
           cp0bubble, md_start, md_busy, pc_redirect
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use and HI/LO hazards, mult/div serialisation,
// CP0 exception/eret flush with a one-cycle FLUSH state and PC redirect pulse.
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input logic             clk,
  input logic             rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, MD_WAIT, FLUSH} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             start_q;
  logic             redir_q;
  logic [1:0]       cpb_q;

  logic exc_any;
  logic lu;
  logic hl;
  logic stall;
  logic start_ok;
  logic cnt_zero;

  assign exc_any  = bus.mem_exc | bus.mem_eret;
  assign cnt_zero = (cnt == '0);
  assign lu = (state != FLUSH) & bus.ex_regWr & (bus.ex_memtoreg == 2'd1) &
              (bus.ex_rw != 5'd0) &
              ((bus.id_uses_rs & (bus.id_rs == bus.ex_rw)) |
               (bus.id_uses_rt & (bus.id_rt == bus.ex_rw)));
  assign hl = busy_q & (bus.id_reads_hl | (bus.id_md_op != 2'b00));
  // A flush in progress outranks any stall so the redirect is never held off.
  assign stall    = (lu | hl) & ~exc_any & (state != FLUSH);
  assign start_ok = (state == RUN) & ((bus.id_md_op == 2'b01) | (bus.id_md_op == 2'b10)) &
                    ~stall & ~exc_any;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (exc_any) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        RUN:     if (start_ok) state_nxt = MD_WAIT;
        MD_WAIT: if (cnt_zero) state_nxt = RUN;
        FLUSH:   state_nxt = (busy_q & ~cnt_zero) ? MD_WAIT : RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // The busy counter runs independently of the FSM so a flush never aborts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      redir_q <= 1'b0;
      cpb_q   <= 2'd0;
    end else begin
      start_q <= start_ok;
      redir_q <= exc_any;
      cpb_q   <= bus.mem_exc ? 2'd2 : (bus.mem_eret ? 2'd1 : 2'd0);
      if (start_ok) begin
        busy_q <= 1'b1;
        cnt    <= (bus.id_md_op == 2'b01) ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
      end else if (busy_q) begin
        if (cnt_zero) busy_q <= 1'b0;
        else          cnt    <= cnt - 1'b1;
      end
    end
  end

  logic       o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_flush, o_exmem_flush;
  logic       o_md_start, o_md_busy, o_pc_redirect;
  logic [1:0] o_cp0bubble;
  logic       flush_all;

  always_comb begin
    flush_all     = exc_any | (state == FLUSH);
    o_pc_stall    = 1'b0;
    o_ifid_stall  = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;
    o_exmem_flush = 1'b0;
    o_cp0bubble   = 2'd0;
    o_md_start    = 1'b0;
    o_md_busy     = 1'b0;
    o_pc_redirect = 1'b0;
    if (rst_n) begin
      o_pc_stall    = stall;
      o_ifid_stall  = stall;
      o_ifid_flush  = flush_all;
      o_idex_flush  = flush_all | stall;
      o_exmem_flush = flush_all;
      o_cp0bubble   = cpb_q;
      o_md_start    = start_q;
      o_md_busy     = busy_q;
      o_pc_redirect = redir_q;
    end
  end

  assign bus.pc_stall    = o_pc_stall;
  assign bus.ifid_stall  = o_ifid_stall;
  assign bus.ifid_flush  = o_ifid_flush;
  assign bus.idex_flush  = o_idex_flush;
  assign bus.exmem_flush = o_exmem_flush;
  assign bus.cp0bubble   = o_cp0bubble;
  assign bus.md_start    = o_md_start;
  assign bus.md_busy     = o_md_busy;
  assign bus.pc_redirect = o_pc_redirect;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; expected output vectors are queued
// by the stimulus process and checked by an independent negedge monitor.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush, cp0bubble[1:0], md_start, md_busy, pc_redirect}
  localparam logic [9:0] NONE  = 10'h000;
  localparam logic [9:0] STALL = 10'h340;
  localparam logic [9:0] FL    = 10'h0E0;
  localparam logic [9:0] CB1   = 10'h008;
  localparam logic [9:0] CB2   = 10'h010;
  localparam logic [9:0] MS    = 10'h004;
  localparam logic [9:0] BZ    = 10'h002;
  localparam logic [9:0] PR    = 10'h001;

  string      name_q[$];
  logic [9:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  logic [9:0] act;
  assign act = {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_flush,
                bus.exmem_flush, bus.cp0bubble, bus.md_start, bus.md_busy, bus.pc_redirect};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      string      nm;
      logic [9:0] e;
      nm = name_q.pop_front();
      e  = exp_q.pop_front();
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL %s: got %b expected %b", nm, act, e);
      end
    end
  end

  task automatic idle_in();
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.id_md_op = 2'b00; bus.id_reads_hl = 1'b0;
    bus.ex_rw = 5'd0; bus.ex_regWr = 1'b0; bus.ex_memtoreg = 2'd0;
    bus.mem_exc = 1'b0; bus.mem_eret = 1'b0;
  endtask

  task automatic load_in(input logic [4:0] rw, input logic [1:0] mtr,
                         input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt);
    idle_in();
    bus.ex_rw = rw; bus.ex_regWr = 1'b1; bus.ex_memtoreg = mtr;
    bus.id_rs = rs; bus.id_uses_rs = urs; bus.id_rt = rt; bus.id_uses_rt = urt;
  endtask

  task automatic cyc(input string nm, input logic [9:0] e);
    name_q.push_back(nm);
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_in();
    bus.mem_exc = 1'b1;
    @(posedge clk); #1;

    // reset held with a pending exception
    repeat (3) cyc("reset_hold", NONE);
    rst_n = 1'b1; bus.mem_exc = 1'b0;
    cyc("reset_release", NONE);
    cyc("reset_idle", NONE);

    // load-use
    load_in(5'd5, 2'd1, 5'd5, 1'b1, 5'd0, 1'b0); cyc("lu_rs", STALL);
    idle_in();                                   cyc("lu_rs_after", NONE);
    load_in(5'd7, 2'd1, 5'd1, 1'b1, 5'd7, 1'b1); cyc("lu_rt", STALL);
    load_in(5'd5, 2'd1, 5'd5, 1'b0, 5'd0, 1'b0); cyc("lu_rs_unused", NONE);
    load_in(5'd5, 2'd2, 5'd5, 1'b1, 5'd0, 1'b0); cyc("lu_not_load", NONE);
    load_in(5'd0, 2'd1, 5'd0, 1'b1, 5'd0, 1'b1); cyc("lu_reg0", NONE);
    idle_in();                                   cyc("lu_idle", NONE);

    // div serialisation with mfhi stalling on busy
    bus.id_md_op = 2'b10; cyc("div_accept", NONE);
    idle_in();            cyc("div_start", MS | BZ);
    cyc("div_busy2", BZ);
    bus.id_reads_hl = 1'b1;
    repeat (30) cyc("div_mfhi_stall", STALL | BZ);
    cyc("div_mfhi_go", NONE);
    idle_in();            cyc("div_done_idle", NONE);

    // back-to-back mult
    bus.id_md_op = 2'b01; cyc("mul1_accept", NONE);
    cyc("mul2_held_start", STALL | MS | BZ);
    repeat (3) cyc("mul2_held", STALL | BZ);
    cyc("mul2_accept", NONE);
    idle_in();            cyc("mul2_start", MS | BZ);
    repeat (3) cyc("mul2_busy", BZ);
    cyc("mul2_done", NONE);

    // load-use outranks md_start; op=11 never starts the unit
    load_in(5'd3, 2'd1, 5'd3, 1'b1, 5'd0, 1'b0); bus.id_md_op = 2'b01;
    cyc("lu_blocks_start", STALL);
    idle_in(); bus.id_md_op = 2'b01; cyc("mul_after_lu", NONE);
    idle_in();            cyc("mul_after_lu_start", MS | BZ);
    repeat (3) cyc("mul_after_lu_busy", BZ);
    bus.id_md_op = 2'b11; cyc("mthi", NONE);
    idle_in();            cyc("mthi_no_start", NONE);

    // exception during div: busy unbroken, back to MD_WAIT
    bus.id_md_op = 2'b10; cyc("xdiv_accept", NONE);
    idle_in();            cyc("xdiv_start", MS | BZ);
    repeat (8) cyc("xdiv_busy", BZ);
    bus.mem_exc = 1'b1;   cyc("xdiv_exc", FL | BZ);
    idle_in();            cyc("xdiv_flush", FL | CB2 | PR | BZ);
    repeat (21) cyc("xdiv_busy_after", BZ);
    cyc("xdiv_done", NONE);

    // exception outranks load-use
    load_in(5'd5, 2'd1, 5'd5, 1'b1, 5'd0, 1'b0); bus.mem_exc = 1'b1;
    cyc("exc_over_lu", FL);
    idle_in();            cyc("exc_over_lu_flush", FL | CB2 | PR);
    cyc("exc_over_lu_idle", NONE);

    // exc and eret together, then eret alone
    bus.mem_exc = 1'b1; bus.mem_eret = 1'b1; cyc("both_cycle", FL);
    idle_in();            cyc("both_flush", FL | CB2 | PR);
    cyc("both_idle", NONE);
    bus.mem_eret = 1'b1;  cyc("eret_cycle", FL);
    idle_in();            cyc("eret_flush", FL | CB1 | PR);
    cyc("eret_idle", NONE);

    // repeated exception inside FLUSH restarts it
    bus.mem_exc = 1'b1;   cyc("rexc_1", FL);
    cyc("rexc_2", FL | CB2 | PR);
    idle_in();            cyc("rexc_flush", FL | CB2 | PR);
    cyc("rexc_idle", NONE);

    // reset in the middle of a mult
    bus.id_md_op = 2'b01; cyc("rmul_accept", NONE);
    idle_in();            cyc("rmul_start", MS | BZ);
    rst_n = 1'b0;         cyc("rmul_reset", NONE);
    rst_n = 1'b1;         cyc("rmul_after", NONE);
    repeat (4) cyc("rmul_no_done", NONE);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d checks left unconsumed, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
